// File: rtl/axil_regfile_pkg.sv
// Shared types and the byte-strobe merge helper for the AXI4-Lite register file.
package axil_regfile_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    // Operates at the widest supported data width; callers zero-extend and truncate.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old,
        input logic [MAX_DW-1:0] wdata,
        input logic [MAX_SW-1:0] wstrb
    );
        logic [MAX_DW-1:0] res;
        res = old;
        for (int k = 0; k < MAX_SW; k++) begin
            if (wstrb[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (no PROT signals) with master and slave views.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_regfile_core.sv
// Register array with a byte-strobe write port and a combinational read mux.
// Read-only slots hold no state and read back their status_i slice.
module axil_regfile_core
    import axil_regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter int                    IDX_W      = 2,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [IDX_W-1:0]               wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic [IDX_W-1:0]               rd_idx_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] status_v;

    assign status_v = status_i;
    assign regs_o   = regs_q;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                regs_d[i] = '0;
            end else if (we_i && wr_idx_i == IDX_W'(i)) begin
                regs_d[i] = DATA_WIDTH'(strb_merge(MAX_DW'(regs_q[i]), MAX_DW'(wdata_i),
                                                   MAX_SW'(wstrb_i)));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Out-of-range indices fall through to zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_data_o = RO_MASK[i] ? status_v[i] : regs_q[i];
        end
    end

endmodule

// File: rtl/axil_regfile_slave.sv
// Parametrised AXI4-Lite slave register file: independent write and read FSMs
// around axil_regfile_core. Define AXIL_REGFILE_WPULSE_EN to add wr_pulse_o.
module axil_regfile_slave
    import axil_regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    AXI_LITE.Slave                         axi_l,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
`ifdef AXIL_REGFILE_WPULSE_EN
    ,
    output logic [NUM_REGS-1:0]            wr_pulse_o
`endif
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;

    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    resp_t                 bresp_q, bresp_d;

    rd_state_t             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_t                 rresp_q, rresp_d;

    logic                  rdy_en_q, rdy_en_d;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_commit, wr_ok, rd_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] core_rd;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{axi_l.awaddr[ADDR_LSB-1:0], axi_l.araddr[ADDR_LSB-1:0]};
    assign ar_idx = axi_l.araddr[ADDR_WIDTH-1:ADDR_LSB];

    // Readies stay low until the first edge after reset release.
    assign axi_l.awready = rdy_en_q && (wr_state_q == W_IDLE) && !aw_held_q;
    assign axi_l.wready  = rdy_en_q && (wr_state_q == W_IDLE) && !w_held_q;
    assign axi_l.bvalid  = (wr_state_q == W_RESP);
    assign axi_l.bresp   = bresp_q;
    assign axi_l.arready = rdy_en_q && (rd_state_q == R_IDLE);
    assign axi_l.rvalid  = (rd_state_q == R_RESP);
    assign axi_l.rdata   = rdata_q;
    assign axi_l.rresp   = rresp_q;

    assign aw_hs = axi_l.awvalid && axi_l.awready;
    assign w_hs  = axi_l.wvalid && axi_l.wready;
    assign ar_hs = axi_l.arvalid && axi_l.arready;

    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) wr_ok = 1'b1;
            if (ar_idx == IDX_W'(i)) rd_ok = 1'b1;
        end
    end

    always_comb begin
        rdy_en_d   = 1'b1;
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    wr_commit  = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_ok ? OKAY : SLVERR;
                    wr_state_d = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = axi_l.awaddr[ADDR_WIDTH-1:ADDR_LSB];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = axi_l.wdata;
                        wstrb_d  = axi_l.wstrb;
                    end
                end
            end
            W_RESP: begin
                if (axi_l.bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read data is latched from the pre-commit register value, so a read
    // racing a write to the same slot returns the old contents.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = rd_ok ? core_rd : '0;
                    rresp_d    = rd_ok ? OKAY : SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (axi_l.rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_en_q   <= 1'b0;
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rdy_en_q   <= rdy_en_d;
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    axil_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK),
        .RESET_VAL  (RESET_VAL)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wr_commit && wr_ok),
        .wr_idx_i  (aw_idx_q),
        .wdata_i   (wdata_q),
        .wstrb_i   (wstrb_q),
        .rd_idx_i  (ar_idx),
        .rd_data_o (core_rd),
        .status_i  (status_i),
        .regs_o    (regs_o)
    );

`ifdef AXIL_REGFILE_WPULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_commit && wr_ok && aw_idx_q == IDX_W'(i)) wr_pulse_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wr_pulse_q <= '0;
        else       wr_pulse_q <= wr_pulse_d;
    end

    assign wr_pulse_o = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed self-checking bench for axil_regfile_slave (4 regs, reg 3 read-only, 5-bit address).
module tb_axil_regfile_slave;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR*DW-1:0] status = '0;
    logic [NR*DW-1:0] regs;
    int tests = 0;
    int fails = 0;

    AXI_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_l();

`ifdef AXIL_REGFILE_WPULSE_EN
    logic [NR-1:0] wr_pulse;
    int pcnt [NR] = '{default: 0};
    int align_err = 0;
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pcnt[i] <= pcnt[i] + 1;
        if (wr_pulse != '0 && !axi_l.bvalid) align_err <= align_err + 1;
    end
`endif

    axil_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (4'b1000),
        .RESET_VAL  (32'h0)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .axi_l    (axi_l),
        .status_i (status),
        .regs_o   (regs)
`ifdef AXIL_REGFILE_WPULSE_EN
        ,
        .wr_pulse_o (wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drive AW and W together until both are accepted; leaves bready untouched.
    task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        axi_l.awaddr = a; axi_l.awvalid = 1'b1;
        axi_l.wdata = d; axi_l.wstrb = s; axi_l.wvalid = 1'b1;
        for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            hs_aw = axi_l.awvalid && axi_l.awready;
            hs_w  = axi_l.wvalid && axi_l.wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_done = 1; axi_l.awvalid = 1'b0; end
            if (hs_w)  begin w_done = 1;  axi_l.wvalid = 1'b0; end
        end
        if (!(aw_done && w_done)) begin
            tests++; fails++;
            $display("FAIL write_accept_timeout addr=%h aw=%0d w=%0d", a, aw_done, w_done);
            axi_l.awvalid = 1'b0; axi_l.wvalid = 1'b0;
        end
    endtask

    task automatic finish_write(output logic [1:0] resp);
        bit b_done = 0;
        resp = 2'bxx;
        axi_l.bready = 1'b1;
        for (int n = 0; n < 40 && !b_done; n++) begin
            @(negedge clk);
            if (axi_l.bvalid) begin b_done = 1; resp = axi_l.bresp; end
            @(posedge clk); #1;
        end
        axi_l.bready = 1'b0;
        if (!b_done) begin
            tests++; fails++;
            $display("FAIL write_resp_timeout bvalid never seen");
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        start_write(a, d, s);
        finish_write(resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r,
                            output bit lat_ok);
        bit ar_done = 0, r_done = 0, hs;
        lat_ok = 0; d = 'x; r = 2'bxx;
        axi_l.araddr = a; axi_l.arvalid = 1'b1; axi_l.rready = 1'b0;
        for (int n = 0; n < 40 && !ar_done; n++) begin
            @(negedge clk);
            hs = axi_l.arready;
            @(posedge clk); #1;
            if (hs) begin ar_done = 1; axi_l.arvalid = 1'b0; lat_ok = axi_l.rvalid; end
        end
        axi_l.arvalid = 1'b0;
        axi_l.rready = 1'b1;
        for (int n = 0; n < 40 && ar_done && !r_done; n++) begin
            @(negedge clk);
            if (axi_l.rvalid) begin r_done = 1; d = axi_l.rdata; r = axi_l.rresp; end
            @(posedge clk); #1;
        end
        axi_l.rready = 1'b0;
        if (!r_done) begin
            tests++; fails++;
            $display("FAIL read_timeout addr=%h", a);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic [1:0] r; bit lat;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({axi_l.awready, axi_l.wready, axi_l.arready, axi_l.bvalid, axi_l.rvalid} !== 5'b0) begin
            fails++; $display("FAIL reset_handshake got=%b want=00000",
                {axi_l.awready, axi_l.wready, axi_l.arready, axi_l.bvalid, axi_l.rvalid});
        end
        tests++;
        if ({axi_l.bresp, axi_l.rresp, axi_l.rdata} !== '0) begin
            fails++; $display("FAIL reset_resp bresp=%b rresp=%b rdata=%h", axi_l.bresp, axi_l.rresp, axi_l.rdata);
        end
        tests++;
        if (regs !== '0) begin fails++; $display("FAIL reset_regs got=%h want=0", regs); end
        rst = 1'b0;
        #1;
        tests++;
        if ({axi_l.awready, axi_l.wready, axi_l.arready} !== 3'b000) begin
            fails++; $display("FAIL ready_before_edge got=%b want=000", {axi_l.awready, axi_l.wready, axi_l.arready});
        end
        @(posedge clk); #1;
        tests++;
        if ({axi_l.awready, axi_l.wready, axi_l.arready} !== 3'b111) begin
            fails++; $display("FAIL ready_after_edge got=%b want=111", {axi_l.awready, axi_l.wready, axi_l.arready});
        end
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(4 * i), d, r, lat);
            tests++;
            if (d !== 32'h0 || r !== 2'b00) begin
                fails++; $display("FAIL reset_read_%0d rdata=%h rresp=%b want 0/00", i, d, r);
            end
        end
    endtask

    task automatic test_split_aw_w();
        logic [DW-1:0] d; logic [1:0] r; bit lat, hs;
        axi_l.awaddr = 5'h04; axi_l.awvalid = 1'b1; axi_l.bready = 1'b0;
        @(negedge clk); hs = axi_l.awready;
        @(posedge clk); #1; axi_l.awvalid = 1'b0;
        tests++;
        if (hs !== 1'b1) begin fails++; $display("FAIL split_aw_accept got=%b want=1", hs); end
        repeat (3) @(posedge clk); #1;
        tests++;
        if ({axi_l.bvalid, axi_l.awready, axi_l.wready} !== 3'b001) begin
            fails++; $display("FAIL split_aw_held got=%b want=001", {axi_l.bvalid, axi_l.awready, axi_l.wready});
        end
        axi_l.wdata = 32'hDEADBEEF; axi_l.wstrb = 4'hF; axi_l.wvalid = 1'b1;
        @(negedge clk); hs = axi_l.wready;
        @(posedge clk); #1; axi_l.wvalid = 1'b0;
        tests++;
        if (hs !== 1'b1 || axi_l.bvalid !== 1'b0) begin
            fails++; $display("FAIL split_w_accept wready=%b bvalid=%b want 1/0", hs, axi_l.bvalid);
        end
        @(posedge clk); #1;
        tests++;
        if (axi_l.bvalid !== 1'b1 || axi_l.bresp !== 2'b00) begin
            fails++; $display("FAIL split_bvalid bvalid=%b bresp=%b want 1/00", axi_l.bvalid, axi_l.bresp);
        end
        tests++;
        if (regs[63:32] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL split_regs1 got=%h want=deadbeef", regs[63:32]);
        end
        axi_l.bready = 1'b1;
        @(posedge clk); #1; axi_l.bready = 1'b0;
        tests++;
        if ({axi_l.bvalid, axi_l.awready, axi_l.wready} !== 3'b011) begin
            fails++; $display("FAIL split_b_done got=%b want=011", {axi_l.bvalid, axi_l.awready, axi_l.wready});
        end
        axi_read(5'h04, d, r, lat);
        tests++;
        if (d !== 32'hDEADBEEF || r !== 2'b00 || !lat) begin
            fails++; $display("FAIL split_readback rdata=%h rresp=%b lat=%0d want deadbeef/00/1", d, r, lat);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] resp;
        axi_write(5'h08, 32'h11223344, 4'hF, resp);
        tests++;
        if (regs[95:64] !== 32'h11223344 || resp !== 2'b00) begin
            fails++; $display("FAIL strb_full got=%h resp=%b want 11223344/00", regs[95:64], resp);
        end
        axi_write(5'h08, 32'hAABBCCDD, 4'h5, resp);
        tests++;
        if (regs[95:64] !== 32'h11BB33DD || resp !== 2'b00) begin
            fails++; $display("FAIL strb_partial got=%h resp=%b want 11bb33dd/00", regs[95:64], resp);
        end
    endtask

    task automatic test_ro_decode();
        logic [DW-1:0] d; logic [1:0] r; bit lat; logic [1:0] resp; logic [NR*DW-1:0] snap;
        status[127:96] = 32'hCAFE0001;
        axi_read(5'h0C, d, r, lat);
        tests++;
        if (d !== 32'hCAFE0001 || r !== 2'b00) begin
            fails++; $display("FAIL ro_read rdata=%h rresp=%b want cafe0001/00", d, r);
        end
        snap = regs;
        axi_write(5'h0C, 32'hFFFFFFFF, 4'hF, resp);
        tests++;
        if (resp !== 2'b10 || regs !== snap) begin
            fails++; $display("FAIL ro_write resp=%b regs=%h want 10/%h", resp, regs, snap);
        end
        axi_read(5'h10, d, r, lat);
        tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++; $display("FAIL oob_read rdata=%h rresp=%b want 0/10", d, r);
        end
        axi_write(5'h14, 32'h12345678, 4'hF, resp);
        tests++;
        if (resp !== 2'b10 || regs !== snap) begin
            fails++; $display("FAIL oob_write resp=%b regs=%h want 10/%h", resp, regs, snap);
        end
        axi_write(5'h00, 32'hFFFFFFFF, 4'h0, resp);
        tests++;
        if (resp !== 2'b00 || regs !== snap) begin
            fails++; $display("FAIL zero_strb resp=%b regs=%h want 00/%h", resp, regs, snap);
        end
        axi_read(5'h06, d, r, lat);
        tests++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            fails++; $display("FAIL unaligned_read rdata=%h rresp=%b want deadbeef/00", d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; logic [1:0] r; bit lat, stable; logic [1:0] resp; logic [2:0] rdy;
        start_write(5'h08, 32'h00000055, 4'hF);
        @(posedge clk); #1;
        tests++;
        if (axi_l.bvalid !== 1'b1) begin fails++; $display("FAIL bp_bvalid got=%b want=1", axi_l.bvalid); end
        stable = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if ({axi_l.bvalid, axi_l.bresp, axi_l.awready, axi_l.wready} !== 5'b10000) stable = 0;
        end
        tests++;
        if (!stable) begin fails++; $display("FAIL bp_stable got=0 want=1"); end
        @(posedge clk); #1;
        finish_write(resp);
        tests++;
        if (resp !== 2'b00 || regs[95:64] !== 32'h55) begin
            fails++; $display("FAIL bp_commit resp=%b reg2=%h want 00/00000055", resp, regs[95:64]);
        end
        axi_write(5'h00, 32'h1, 4'hF, resp);
        axi_l.araddr = 5'h00; axi_l.arvalid = 1'b1; axi_l.rready = 1'b0;
        axi_l.awaddr = 5'h00; axi_l.awvalid = 1'b1;
        axi_l.wdata = 32'h2; axi_l.wstrb = 4'hF; axi_l.wvalid = 1'b1; axi_l.bready = 1'b1;
        @(negedge clk); rdy = {axi_l.arready, axi_l.awready, axi_l.wready};
        @(posedge clk); #1;
        axi_l.arvalid = 1'b0; axi_l.awvalid = 1'b0; axi_l.wvalid = 1'b0;
        @(negedge clk); d = axi_l.rdata; axi_l.rready = 1'b1;
        @(posedge clk); #1; axi_l.rready = 1'b0;
        @(posedge clk); #1; axi_l.bready = 1'b0;
        tests++;
        if (rdy !== 3'b111 || d !== 32'h1 || regs[31:0] !== 32'h2) begin
            fails++; $display("FAIL same_cycle rdy=%b rdata=%h reg0=%h want 111/1/2", rdy, d, regs[31:0]);
        end
        axi_read(5'h00, d, r, lat);
        tests++;
        if (d !== 32'h2 || r !== 2'b00) begin
            fails++; $display("FAIL same_cycle_after rdata=%h rresp=%b want 2/00", d, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d; logic [1:0] r; bit lat;
        start_write(5'h04, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({axi_l.bvalid, axi_l.awready, axi_l.wready, axi_l.arready} !== 4'b0000 || regs !== '0) begin
            fails++; $display("FAIL reset_mid bvalid=%b regs=%h want 0/0", axi_l.bvalid, regs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(5'h04, d, r, lat);
        tests++;
        if (d !== 32'h0 || r !== 2'b00) begin
            fails++; $display("FAIL reset_mid_read rdata=%h rresp=%b want 0/00", d, r);
        end
    endtask

`ifdef AXIL_REGFILE_WPULSE_EN
    task automatic test_wpulse();
        logic [1:0] resp; int c1, tot;
        c1 = pcnt[1];
        axi_write(5'h04, 32'hA5A5A5A5, 4'hF, resp);
        tests++;
        if (pcnt[1] !== c1 + 1) begin fails++; $display("FAIL wpulse_ok got=%0d want=%0d", pcnt[1], c1 + 1); end
        tot = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        axi_write(5'h0C, 32'h1, 4'hF, resp);
        tests++;
        if (pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] !== tot) begin
            fails++; $display("FAIL wpulse_slverr got=%0d want=%0d", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], tot);
        end
        tests++;
        if (align_err !== 0) begin fails++; $display("FAIL wpulse_align got=%0d want=0", align_err); end
    endtask
`endif

    initial begin
        axi_l.awaddr = '0; axi_l.awvalid = 1'b0; axi_l.wdata = '0; axi_l.wstrb = '0;
        axi_l.wvalid = 1'b0; axi_l.bready = 1'b0; axi_l.araddr = '0; axi_l.arvalid = 1'b0;
        axi_l.rready = 1'b0;
        test_reset();
        test_split_aw_w();
        test_strobes();
        test_ro_decode();
        test_back_to_back();
        test_reset_mid();
`ifdef AXIL_REGFILE_WPULSE_EN
        test_wpulse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
